// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one overlapping "1100" Mealy detector among
// four word sources; each granted word is shifted MSB-first and its matches counted.
module seq_det_sched #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] data_in,
  output logic [3:0]     grant,
  output logic           busy,
  output logic           ser_bit,
  output logic           ser_valid,
  output logic [CW-1:0]  match_cnt,
  output logic           done,
  output logic [1:0]     done_id
);

  localparam int BW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {D0, D1, D2, D3} det_t;

  state_t         state, state_next;
  det_t           det, det_next;
  logic           match;
  logic [W-1:0]   shreg;
  logic [BW-1:0]  bit_cnt;
  logic [1:0]     rr_ptr;
  logic [1:0]     owner;

  logic [W-1:0]   words [4];
  logic [3:0]     rot_req;
  logic [1:0]     offset;
  logic [1:0]     pick;
  logic           pick_valid;

  // rot_req[0] is the requester at rr_ptr, so the lowest set bit wins.
  for (genvar gi = 0; gi < 4; gi++) begin : g_req
    assign words[gi]   = data_in[gi*W +: W];
    assign rot_req[gi] = req[2'(gi) + rr_ptr];
  end

  always_comb begin
    offset     = 2'd0;
    pick_valid = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) begin
        offset     = 2'(k);
        pick_valid = 1'b1;
      end
    end
    pick = rr_ptr + offset;
  end

  always_comb begin
    det_next = det;
    match    = 1'b0;
    case (det)
      D0: det_next = shreg[W-1] ? D1 : D0;
      D1: det_next = shreg[W-1] ? D2 : D0;
      D2: det_next = shreg[W-1] ? D2 : D3;
      D3: begin
        if (shreg[W-1]) begin
          det_next = D1;
        end else begin
          det_next = D0;
          match    = 1'b1;
        end
      end
      default: det_next = D0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = SHIFT;
      SHIFT:   if (bit_cnt == BW'(W - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      det       <= D0;
      shreg     <= '0;
      bit_cnt   <= '0;
      rr_ptr    <= 2'd0;
      owner     <= 2'd0;
      grant     <= 4'b0;
      match_cnt <= '0;
      done_id   <= 2'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant     <= 4'b0001 << pick;
            owner     <= pick;
            shreg     <= words[pick];
            match_cnt <= '0;
            bit_cnt   <= '0;
            det       <= D0;
            rr_ptr    <= pick + 2'd1;
          end
        end
        SHIFT: begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + BW'(1);
          det     <= det_next;
          if (match && (match_cnt != {CW{1'b1}}))
            match_cnt <= match_cnt + CW'(1);
          // done_id only moves at job end so it holds across the next E0.
          if (bit_cnt == BW'(W - 1))
            done_id <= owner;
        end
        DONE: grant <= 4'b0;
        default: grant <= 4'b0;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign ser_valid = (state == SHIFT);
  assign ser_bit   = ser_valid & shreg[W-1];
  assign done      = (state == DONE);

endmodule

// File: doc/seq_det_sched.md
Name: seq_det_sched

Overview:
- Round-robin scheduler that shares one overlapping "1100" serial pattern detector between 4 requesters.
- Each requester presents a W-bit parallel word. The winner's word is latched and shifted MSB-first through the embedded Mealy detector, one bit per clock.
- The number of matches is returned with a one-cycle done pulse.
- Sits between the memory read ports (RAM/ROM words) and the sequence-detection datapath, so multiple word sources can use a single detector.

Parameters:
- W, 8, word width; bits shifted per job (W >= 4).
- CW, 4, width of match_cnt; count saturates at 2^CW-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- req  input  4  per-requester request; must be held until the matching grant bit rises.
- data_in  input  4*W  packed words; requester i occupies bits [i*W +: W]. Must be valid while req[i]=1.
- grant  output  4  one-hot; identifies the job owner from grant edge through the done cycle.
- busy  output  1  high in SHIFT and DONE.
- ser_bit  output  1  bit currently fed to the detector (shift-register MSB); 0 when not SHIFT.
- ser_valid  output  1  high in SHIFT.
- match_cnt  output  CW  running, then final, match count of the current or last job.
- done  output  1  one-cycle pulse at job completion.
- done_id  output  2  index of the finished requester; valid while done=1, held afterwards.

Behaviour:
- Reset values:
  - FSM=IDLE, detector state=D0, rr pointer=0 (req[0] highest priority).
  - grant=0, busy=0, ser_bit=0, ser_valid=0, match_cnt=0, done=0, done_id=0.
  - Shift register and bit counter = 0.
- Scheduler FSM:
  - IDLE: if req≠0, pick the first set bit searching from rr_ptr upward, wrapping 3→0.
    - At the clock edge: set grant one-hot; latch that word into the shift register; clear match_cnt, bit counter and detector state (D0); set rr_ptr = winner+1 mod 4; go SHIFT.
    - If req=0, stay in IDLE.
  - SHIFT: each edge consumes the MSB, shifts left, increments the bit counter, and steps the detector. After the W-th bit go DONE.
  - DONE: done=1 and done_id=winner for exactly one cycle; grant is still held. The next edge clears grant and returns to IDLE.
- Detector, Mealy, overlapping, pattern 1100:
  - D0: 1→D1, 0→D0.
  - D1: 1→D2, 0→D0.
  - D2: 1→D2, 0→D3.
  - D3: 0→D0 with match; 1→D1.
  - A match increments match_cnt at the edge that consumes the bit.
- Saturation: match_cnt saturates at 2^CW-1.
- Timing:
  - grant rises at edge E0, where req is sampled.
  - Bits are consumed at E1..EW.
  - done is high for the cycle after EW.
  - Earliest next grant is the edge after the done cycle, so there is one IDLE cycle between back-to-back jobs.
- Detector isolation: detector state is reset at each job start. A pattern spanning two jobs never matches.
- Input changes mid-job: changes to req or data_in after E0 are ignored until the FSM is back in IDLE.
- Held requests: a requester still requesting in IDLE competes under round-robin. With all four held, grants go 0,1,2,3,0,…
- match_cnt and done_id hold their values from the done cycle until the next job's E0.
- Reset mid-job: the job is aborted with no done pulse, all outputs return to reset values, and rr_ptr returns to 0.

Test Plan:
- Basic match count:
  - req=0001, data0=8'b11001100 → grant=0001 at E0.
  - ser_bit sequence 1,1,0,0,1,1,0,0.
  - match_cnt=2, done=1 at cycle E8+1, done_id=0.
- Single and zero matches:
  - data=8'b11100110 → match_cnt=1.
  - data=8'hFF → match_cnt=0, and done still pulses.
- Round-robin order: req=1111 held for 4 jobs → grant sequence 0001,0010,0100,1000; done_id 0,1,2,3. A 5th job grants 0001.
- Cross-job isolation: job A data=8'b00000110, job B data=8'b00000000 back-to-back → both report match_cnt=0.
- Reset mid-job: assert reset at E4 of a job on req[2] → grant=0, busy=0, no done pulse. After release, req=0101 → grant 0001 first.
- Saturation: W=16, CW=2, data=16'hCCCC (4 matches) → match_cnt=3.
